// File: rtl/id_stage_hazard.sv
// id_stage_hazard: MIPS instruction-decode stage.
//   Holds the register file (write-through from WB), decodes the IF/ID
//   instruction, resolves jumps and branches in ID, detects load-use and
//   branch-operand hazards, and owns the ID/EX pipeline register.
//
// Optional build macro: ID_FORWARD_EN
//   When defined, a branch/JR operand produced by a non-load instruction in
//   MEM is taken from i_mem_alu_result instead of stalling.
//
// Ports:
//   clk, i_rst_n            clock, async active-low reset
//   i_valid, i_instruction, i_pc4, i_flush   IF/ID inputs and flush
//   i_wb_we/addr/data       register-file write port
//   i_mem_rd/regwrite/memread/alu_result     MEM-stage producer info
//   o_stall, o_jump_taken, o_jump_target     combinational to IF
//   o_ex_*                  registered ID/EX entry
module id_stage_hazard #(
    parameter int NB_DATA  = 32,
    parameter int NB_ADDR  = 5,
    parameter int LINK_REG = 31
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [31:0]        i_instruction,
    input  logic [NB_DATA-1:0] i_pc4,
    input  logic               i_flush,
    input  logic               i_wb_we,
    input  logic [NB_ADDR-1:0] i_wb_addr,
    input  logic [NB_DATA-1:0] i_wb_data,
    input  logic [NB_ADDR-1:0] i_mem_rd,
    input  logic               i_mem_regwrite,
    input  logic               i_mem_memread,
    input  logic [NB_DATA-1:0] i_mem_alu_result,
    output logic               o_stall,
    output logic               o_jump_taken,
    output logic [NB_DATA-1:0] o_jump_target,
    output logic               o_ex_valid,
    output logic [NB_DATA-1:0] o_ex_rs_data,
    output logic [NB_DATA-1:0] o_ex_rt_data,
    output logic [NB_DATA-1:0] o_ex_imm,
    output logic [NB_ADDR-1:0] o_ex_rs,
    output logic [NB_ADDR-1:0] o_ex_rt,
    output logic [NB_ADDR-1:0] o_ex_dest,
    output logic [5:0]         o_ex_opcode,
    output logic [5:0]         o_ex_func,
    output logic [4:0]         o_ex_shamt,
    output logic               o_ex_regwrite,
    output logic               o_ex_memread,
    output logic               o_ex_memwrite,
    output logic               o_ex_link,
    output logic [1:0]         o_ex_width,
    output logic               o_ex_unsigned
);

`ifdef ID_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif
    localparam int NREG = 2**NB_ADDR;

    // ---------------- instruction fields ----------------
    logic [5:0]         op, func;
    logic [4:0]         shamt;
    logic [15:0]        imm16;
    logic [NB_ADDR-1:0] rs, rt, rd;

    assign op    = i_instruction[31:26];
    assign rs    = NB_ADDR'(i_instruction[25:21]);
    assign rt    = NB_ADDR'(i_instruction[20:16]);
    assign rd    = NB_ADDR'(i_instruction[15:11]);
    assign shamt = i_instruction[10:6];
    assign func  = i_instruction[5:0];
    assign imm16 = i_instruction[15:0];

    // ---------------- register file ----------------
    logic [NB_DATA-1:0] rf_q [NREG];
    logic [NB_DATA-1:0] rs_val, rt_val;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (i_wb_we && i_wb_addr != '0) begin
            rf_q[i_wb_addr] <= i_wb_data;
        end
    end

    // Write-through: a same-cycle WB write is visible to the decode reads.
    // R0 is never written, so rf_q[0] stays zero.
    assign rs_val = (i_wb_we && i_wb_addr == rs && rs != '0) ? i_wb_data : rf_q[rs];
    assign rt_val = (i_wb_we && i_wb_addr == rt && rt != '0) ? i_wb_data : rf_q[rt];

    // ---------------- decode ----------------
    logic               dec_regwrite, dec_memread, dec_memwrite, dec_link;
    logic               uses_rt, is_jr, is_j, is_br;
    logic [NB_ADDR-1:0] dec_dest;
    logic [NB_DATA-1:0] dec_imm;

    always_comb begin
        dec_regwrite = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_link     = 1'b0;
        uses_rt      = 1'b0;
        is_jr        = 1'b0;
        is_j         = 1'b0;
        is_br        = 1'b0;
        dec_dest     = rt;
        dec_imm      = {{(NB_DATA-16){imm16[15]}}, imm16};
        casez (op)
            6'b000000: begin
                dec_dest     = rd;
                uses_rt      = 1'b1;
                dec_regwrite = (func != 6'h08);
                dec_link     = (func == 6'h09);
                is_jr        = (func == 6'h08) || (func == 6'h09);
            end
            6'h02: is_j = 1'b1;
            6'h03: begin
                is_j         = 1'b1;
                dec_regwrite = 1'b1;
                dec_link     = 1'b1;
                dec_dest     = NB_ADDR'(LINK_REG);
            end
            6'h04, 6'h05: begin
                is_br   = 1'b1;
                uses_rt = 1'b1;
            end
            6'b001???: begin
                dec_regwrite = 1'b1;
                if (op == 6'h0C || op == 6'h0D || op == 6'h0E)
                    dec_imm = {{(NB_DATA-16){1'b0}}, imm16};
                else if (op == 6'h0F) begin
                    dec_imm       = '0;
                    dec_imm[31:0] = {imm16, 16'h0000};
                end
            end
            6'b100???: begin
                dec_memread  = 1'b1;
                dec_regwrite = 1'b1;
            end
            6'b101???: begin
                dec_memwrite = 1'b1;
                uses_rt      = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- hazards ----------------
    logic rs_chk, rt_chk;
    logic load_use, ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic mem_fwd_rs, mem_fwd_rt, br_haz;

    assign rs_chk     = (rs != '0);
    assign rt_chk     = uses_rt && (rt != '0);
    assign load_use   = o_ex_valid && o_ex_memread &&
                        ((rs_chk && o_ex_dest == rs) || (rt_chk && o_ex_dest == rt));
    assign ex_hit_rs  = o_ex_valid && o_ex_regwrite && rs_chk && o_ex_dest == rs;
    assign ex_hit_rt  = o_ex_valid && o_ex_regwrite && rt_chk && o_ex_dest == rt;
    assign mem_hit_rs = i_mem_regwrite && rs_chk && i_mem_rd == rs;
    assign mem_hit_rt = i_mem_regwrite && rt_chk && i_mem_rd == rt;
    // A non-load MEM producer already has its result; a load does not.
    assign mem_fwd_rs = FWD_EN && mem_hit_rs && !i_mem_memread;
    assign mem_fwd_rt = FWD_EN && mem_hit_rt && !i_mem_memread;
    assign br_haz     = (is_br || is_jr) &&
                        (ex_hit_rs || ex_hit_rt ||
                         (mem_hit_rs && !mem_fwd_rs) || (mem_hit_rt && !mem_fwd_rt));
    assign o_stall    = i_valid && (load_use || br_haz);

    // ---------------- jump / branch resolution ----------------
    logic [NB_DATA-1:0] br_rs, br_rt;
    logic               br_eq;

    assign br_rs = mem_fwd_rs ? i_mem_alu_result : rs_val;
    assign br_rt = mem_fwd_rt ? i_mem_alu_result : rt_val;
    assign br_eq = (br_rs == br_rt);

    assign o_jump_taken = i_valid && !o_stall &&
                          (is_j || is_jr || (op == 6'h04 && br_eq) || (op == 6'h05 && !br_eq));

    always_comb begin
        o_jump_target = i_pc4 + {dec_imm[NB_DATA-3:0], 2'b00};
        if (is_j) begin
            o_jump_target       = i_pc4;
            o_jump_target[31:0] = {i_pc4[31:28], i_instruction[25:0], 2'b00};
        end else if (is_jr) begin
            o_jump_target = br_rs;
        end
    end

    // ---------------- ID/EX register ----------------
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ex_valid    <= 1'b0;
            o_ex_rs_data  <= '0;
            o_ex_rt_data  <= '0;
            o_ex_imm      <= '0;
            o_ex_rs       <= '0;
            o_ex_rt       <= '0;
            o_ex_dest     <= '0;
            o_ex_opcode   <= '0;
            o_ex_func     <= '0;
            o_ex_shamt    <= '0;
            o_ex_regwrite <= 1'b0;
            o_ex_memread  <= 1'b0;
            o_ex_memwrite <= 1'b0;
            o_ex_link     <= 1'b0;
            o_ex_width    <= '0;
            o_ex_unsigned <= 1'b0;
        end else if (i_flush || o_stall || !i_valid) begin
            o_ex_valid <= 1'b0;  // bubble; payload fields hold
        end else begin
            o_ex_valid    <= 1'b1;
            // Link instructions compute pc4 + 0 in EX.
            o_ex_rs_data  <= dec_link ? i_pc4 : rs_val;
            o_ex_rt_data  <= dec_link ? '0 : rt_val;
            o_ex_imm      <= dec_imm;
            o_ex_rs       <= rs;
            o_ex_rt       <= rt;
            o_ex_dest     <= dec_dest;
            o_ex_opcode   <= op;
            o_ex_func     <= func;
            o_ex_shamt    <= shamt;
            o_ex_regwrite <= dec_regwrite;
            o_ex_memread  <= dec_memread;
            o_ex_memwrite <= dec_memwrite;
            o_ex_link     <= dec_link;
            o_ex_width    <= op[1:0];
            o_ex_unsigned <= op[2];
        end
    end

endmodule

// File: tb/tb_id_stage_hazard.sv
module tb_id_stage_hazard;
    logic        clk, i_rst_n, i_valid, i_flush;
    logic [31:0] i_instruction, i_pc4;
    logic        i_wb_we;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic [4:0]  i_mem_rd;
    logic        i_mem_regwrite, i_mem_memread;
    logic [31:0] i_mem_alu_result;
    logic        o_stall, o_jump_taken;
    logic [31:0] o_jump_target;
    logic        o_ex_valid;
    logic [31:0] o_ex_rs_data, o_ex_rt_data, o_ex_imm;
    logic [4:0]  o_ex_rs, o_ex_rt, o_ex_dest;
    logic [5:0]  o_ex_opcode, o_ex_func;
    logic [4:0]  o_ex_shamt;
    logic        o_ex_regwrite, o_ex_memread, o_ex_memwrite, o_ex_link;
    logic [1:0]  o_ex_width;
    logic        o_ex_unsigned;

    int total = 0;
    int bad   = 0;

    id_stage_hazard dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_instruction(i_instruction),
        .i_pc4(i_pc4), .i_flush(i_flush), .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr),
        .i_wb_data(i_wb_data), .i_mem_rd(i_mem_rd), .i_mem_regwrite(i_mem_regwrite),
        .i_mem_memread(i_mem_memread), .i_mem_alu_result(i_mem_alu_result),
        .o_stall(o_stall), .o_jump_taken(o_jump_taken), .o_jump_target(o_jump_target),
        .o_ex_valid(o_ex_valid), .o_ex_rs_data(o_ex_rs_data), .o_ex_rt_data(o_ex_rt_data),
        .o_ex_imm(o_ex_imm), .o_ex_rs(o_ex_rs), .o_ex_rt(o_ex_rt), .o_ex_dest(o_ex_dest),
        .o_ex_opcode(o_ex_opcode), .o_ex_func(o_ex_func), .o_ex_shamt(o_ex_shamt),
        .o_ex_regwrite(o_ex_regwrite), .o_ex_memread(o_ex_memread),
        .o_ex_memwrite(o_ex_memwrite), .o_ex_link(o_ex_link), .o_ex_width(o_ex_width),
        .o_ex_unsigned(o_ex_unsigned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_instruction = '0; i_pc4 = '0;
        i_wb_we = 1'b0; i_wb_addr = '0; i_wb_data = '0;
        i_mem_rd = '0; i_mem_regwrite = 1'b0; i_mem_memread = 1'b0; i_mem_alu_result = '0;
        #12;
        chk("rst_valid", o_ex_valid, 0);
        chk("rst_rsdata", o_ex_rs_data, 0);
        chk("rst_dest", o_ex_dest, 0);
        chk("rst_stall", o_stall, 0);
        i_rst_n = 1'b1;

        // WB write-through of R5 into same-cycle ADD
        i_wb_we = 1; i_wb_addr = 5; i_wb_data = 32'h1234;
        i_valid = 1; i_instruction = rtype(5, 0, 6, 6'h20);
        #1 chk("add_nostall", o_stall, 0);
        tick();
        chk("wt_valid", o_ex_valid, 1);
        chk("wt_rsdata", o_ex_rs_data, 32'h1234);
        chk("wt_dest", o_ex_dest, 6);
        chk("wt_regwrite", o_ex_regwrite, 1);

        // R5 stored; R1=7 via write-through on rt
        i_wb_addr = 1; i_wb_data = 7; i_instruction = rtype(5, 1, 6, 6'h20);
        tick();
        chk("r5_stored", o_ex_rs_data, 32'h1234);
        chk("r1_wt", o_ex_rt_data, 7);

        // R2=7, and an attempted R0 write is ignored even on write-through
        i_wb_addr = 2; i_wb_data = 7; i_instruction = rtype(1, 0, 7, 6'h20);
        tick();
        i_wb_addr = 0; i_wb_data = 32'hDEAD; i_instruction = rtype(0, 2, 7, 6'h20);
        tick();
        chk("r0_wt", o_ex_rs_data, 0);
        chk("r2_read", o_ex_rt_data, 7);
        i_wb_we = 0; i_instruction = rtype(0, 0, 7, 6'h20);
        tick();
        chk("r0_read", o_ex_rs_data, 0);

        // Load-use: LW R3 then ADD R4,R3,R1
        i_instruction = itype(6'h23, 0, 3, 16'h0004);
        tick();
        chk("lw_valid", o_ex_valid, 1);
        chk("lw_memread", o_ex_memread, 1);
        chk("lw_dest", o_ex_dest, 3);
        chk("lw_width", o_ex_width, 2'b11);
        chk("lw_imm", o_ex_imm, 4);
        i_instruction = rtype(3, 1, 4, 6'h20);
        #1 chk("lu_stall", o_stall, 1);
        tick();
        chk("lu_bubble", o_ex_valid, 0);
        chk("lu_release", o_stall, 0);
        tick();
        chk("lu_cap_valid", o_ex_valid, 1);
        chk("lu_cap_dest", o_ex_dest, 4);

        // BEQ / BNE R1,R2 (both 7), imm=-2, pc4=0x100
        i_pc4 = 32'h100; i_instruction = itype(6'h04, 1, 2, 16'hFFFE);
        #1 chk("beq_stall", o_stall, 0);
        chk("beq_taken", o_jump_taken, 1);
        chk("beq_target", o_jump_target, 32'hF8);
        i_instruction = itype(6'h05, 1, 2, 16'hFFFE);
        #1 chk("bne_taken", o_jump_taken, 0);
        tick();

        // JAL
        i_pc4 = 32'h104; i_instruction = {6'h03, 26'h40};
        #1 chk("jal_taken", o_jump_taken, 1);
        chk("jal_target", o_jump_target, 32'h100);
        tick();
        chk("jal_dest", o_ex_dest, 31);
        chk("jal_link", o_ex_link, 1);
        chk("jal_rsdata", o_ex_rs_data, 32'h104);
        chk("jal_rtdata", o_ex_rt_data, 0);
        chk("jal_regwrite", o_ex_regwrite, 1);

        // BNE R8,R0 with R8 produced in MEM (R8 in file = 0, MEM result = 5)
        i_pc4 = 32'h200; i_instruction = itype(6'h05, 8, 0, 16'h0010);
        i_mem_rd = 8; i_mem_regwrite = 1; i_mem_memread = 1; i_mem_alu_result = 5;
        #1 chk("mem_load_stall", o_stall, 1);
        i_mem_memread = 0;
        #1;
`ifdef ID_FORWARD_EN
        chk("mem_fwd_stall", o_stall, 0);
        chk("mem_fwd_taken", o_jump_taken, 1);
        chk("mem_fwd_target", o_jump_target, 32'h240);
        tick();
        chk("mem_fwd_valid", o_ex_valid, 1);
`else
        chk("mem_stall", o_stall, 1);
        chk("mem_stall_taken", o_jump_taken, 0);
        tick();
        chk("mem_stall_bubble", o_ex_valid, 0);
`endif
        i_mem_regwrite = 0; i_mem_rd = 0; i_mem_alu_result = 0;

        // EX-producer branch hazard
        i_instruction = rtype(1, 2, 9, 6'h20);
        tick();
        i_instruction = itype(6'h04, 9, 0, 16'h0001);
        #1 chk("ex_br_stall", o_stall, 1);
        chk("ex_br_taken", o_jump_taken, 0);
        tick();
        chk("ex_br_bubble", o_ex_valid, 0);

        // Flush kills a valid ORI
        i_instruction = itype(6'h0D, 1, 10, 16'h8000); i_flush = 1;
        tick();
        chk("flush_valid", o_ex_valid, 0);
        i_flush = 0;
        tick();
        chk("ori_valid", o_ex_valid, 1);
        chk("ori_imm", o_ex_imm, 32'h0000_8000);
        chk("ori_dest", o_ex_dest, 10);
        i_instruction = itype(6'h08, 1, 10, 16'h8000);
        tick();
        chk("addi_imm", o_ex_imm, 32'hFFFF_8000);
        i_instruction = itype(6'h0F, 0, 10, 16'h8000);
        tick();
        chk("lui_imm", o_ex_imm, 32'h8000_0000);
        i_instruction = itype(6'h24, 0, 11, 16'h0000);
        tick();
        chk("lbu_width", o_ex_width, 2'b00);
        chk("lbu_unsigned", o_ex_unsigned, 1);
        i_instruction = itype(6'h2B, 0, 2, 16'h0008);
        #1 chk("sw_nostall", o_stall, 0);
        tick();
        chk("sw_memwrite", o_ex_memwrite, 1);
        chk("sw_regwrite", o_ex_regwrite, 0);

        // Mid-stream async reset
        #2 i_rst_n = 0;
        #1;
        chk("mrst_valid", o_ex_valid, 0);
        chk("mrst_dest", o_ex_dest, 0);
        chk("mrst_imm", o_ex_imm, 0);
        chk("mrst_memwrite", o_ex_memwrite, 0);
        i_rst_n = 1;
        i_instruction = rtype(5, 1, 6, 6'h20);
        tick();
        chk("mrst_r5", o_ex_rs_data, 0);
        chk("mrst_r1", o_ex_rt_data, 0);
        chk("mrst_cap", o_ex_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_stage_hazard.md
Name: id_stage_hazard

Overview:
- Second-generation MIPS instruction-decode stage sitting between the IF/ID and ID/EX boundaries of the 5-stage pipeline.
- Holds the architectural register file, decodes the instruction and resolves branches/jumps in ID.
- Detects load-use and branch-operand hazards and drives the stall to IF, with an explicit valid bit on the ID/EX register.
- Adds over the previous decode stage: width/depth parametrisation, WB write-through bypass, bubble insertion, and a flush input.

Parameters:
- NB_DATA, 32, datapath width; must be ≥ 32. Instruction width is fixed at 32.
- NB_ADDR, 5, register index width; the register file has 2**NB_ADDR entries.
- LINK_REG, 31, destination index used by JAL.

Ports:
- clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  IF/ID holds a valid instruction
- i_instruction  in  32  instruction word
- i_pc4  in  NB_DATA  PC+4 of the instruction
- i_flush  in  1  kill the instruction entering ID/EX
- i_wb_we / i_wb_addr / i_wb_data  in  1/NB_ADDR/NB_DATA  register-file write port
- i_mem_rd / i_mem_regwrite / i_mem_memread  in  NB_ADDR/1/1  MEM-stage producer info
- i_mem_alu_result  in  NB_DATA  MEM-stage ALU result (used only under ID_FORWARD_EN)
- o_stall  out  1  hold PC and IF/ID (combinational)
- o_jump_taken  out  1  redirect PC (combinational)
- o_jump_target  out  NB_DATA  redirect address (combinational)
- o_ex_valid  out  1  ID/EX entry valid
- o_ex_rs_data / o_ex_rt_data / o_ex_imm  out  NB_DATA each  operands and extended immediate
- o_ex_rs / o_ex_rt / o_ex_dest  out  NB_ADDR each  source and destination indices
- o_ex_opcode / o_ex_func / o_ex_shamt  out  6/6/5  instruction fields
- o_ex_regwrite / o_ex_memread / o_ex_memwrite / o_ex_link  out  1 each  control
- o_ex_width / o_ex_unsigned  out  2/1  memory width (op[1:0]) and unsigned flag (op[2])

Behaviour:
- Reset (async): all registered outputs are 0 and every register-file entry is 0.
- Register file: R0 reads 0 and ignores writes. Writes happen on posedge clk.
  - Reads are combinational with write-through: when i_wb_we=1 and i_wb_addr equals a nonzero source index, the read returns i_wb_data.
- Decode:
  - op=0 (R-type): dest=rd; regwrite=1 except JR (func 0x08).
  - JALR (func 0x09): link=1, dest=rd.
  - op 0x08–0x0F (I-type ALU): dest=rt. Immediate is zero-extended for 0x0C/0x0D/0x0E, placed as {imm,16'b0} for LUI (0x0F), and sign-extended otherwise.
  - op 100xxx (loads): memread=1, regwrite=1, dest=rt.
  - op 101xxx (stores): memwrite=1, regwrite=0.
  - JAL (0x03): regwrite=1, link=1, dest=LINK_REG.
  - For link instructions, o_ex_rs_data=i_pc4 and o_ex_rt_data=0; the EX stage adds them.
- Jumps/branches (valid only when i_valid=1 and o_stall=0):
  - J/JAL target = {i_pc4[31:28], instr[25:0], 2'b00}.
  - JR/JALR target = rs data.
  - BEQ (0x04) / BNE (0x05) target = i_pc4 + (sext(imm)<<2), taken when rs==rt / rs!=rt.
  - The wrong-path IF/ID squash is owned by the fetch stage.
- Hazards (source index 0 never hazards; rt counts only for R-type, stores, BEQ and BNE):
  - Load-use: the ID/EX entry has valid=1, memread=1 and dest equal to rs or rt → o_stall=1.
  - Branch/JR operand: either source equals the EX dest (valid=1, regwrite=1), or equals i_mem_rd with i_mem_regwrite=1 → o_stall=1.
- Pipeline register update each posedge:
  - i_flush=1: o_ex_valid←0.
  - Else o_stall=1 or i_valid=0: o_ex_valid←0 (bubble); the other ex fields may hold.
  - Else capture all decoded fields and set o_ex_valid←1.
  - Flush has priority; o_stall still reflects the hazard during a flush.
  - WB writes proceed regardless of stall or flush.
  - A load in EX followed by a dependent branch stalls 2 cycles: once as a load-use hazard, then again as a MEM producer.

Optional Feature:
- ID_FORWARD_EN defined: a branch/JR operand whose producer is in MEM with i_mem_memread=0 takes i_mem_alu_result and does not stall. An EX producer or a MEM load still stalls.
- Undefined: i_mem_alu_result is ignored and every MEM producer stalls.

Test Plan:
- Write R5=0x1234 via WB while decoding ADD using rs=5 in the same cycle → o_ex_rs_data=0x1234 on the next edge; a write to R0 later reads 0.
- LW R3 captured into ID/EX, then ADD R4,R3,R1 in ID → o_stall=1 for 1 cycle and o_ex_valid=0; next cycle ADD is captured with o_ex_valid=1.
- R1=R2=7, BEQ R1,R2,imm=-2, i_pc4=0x100 → o_jump_taken=1, o_jump_target=0xF8. With BNE → o_jump_taken=0.
- JAL instr[25:0]=0x40, i_pc4=0x0000_0104 → target 0x100, o_ex_dest=31, o_ex_link=1, o_ex_rs_data=0x104.
- BEQ on R8 with i_mem_rd=8, i_mem_regwrite=1, i_mem_memread=0 → with ID_FORWARD_EN no stall and the compare uses i_mem_alu_result; without it o_stall=1.
- i_flush=1 together with a valid ORI → o_ex_valid=0. Assert i_rst_n low mid-stream → all outputs 0 immediately and the register file is cleared.
